// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the single-digit decoder codes, the digit/position counts, the
// segment/anode constants, the shadow/active display record, and a helper
// that replaces non-BCD nibbles with the blank code.
package seg_scan_ctrl_pkg;

    localparam int NUM_POS = 4;   // anode positions on the board
    localparam int NUM_DIG = 5;   // BCD digits held in the value

    localparam logic [3:0] MINUS = 4'hA;
    localparam logic [3:0] BLANK = 4'hF;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low anode enables, bit 0 is the rightmost position.
    typedef logic [NUM_POS-1:0] an_mask_t;
    localparam an_mask_t AN_OFF = '1;

    // One complete display value, as held in the shadow and active registers.
    typedef struct packed {
        logic [4*NUM_DIG-1:0] digits;
        logic                 neg;
        logic                 window;
    } disp_val_t;

    localparam disp_val_t DISP_ZERO = '0;

    // Any nibble above 9 is not a decimal digit; store it as blank so the
    // decoder shows nothing at that position.
    function automatic logic [4*NUM_DIG-1:0] sanitize_bcd(input logic [4*NUM_DIG-1:0] raw);
        logic [4*NUM_DIG-1:0] clean;
        clean = raw;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (raw[4*i +: 4] > 4'd9) begin
                clean[4*i +: 4] = BLANK;
            end
        end
        return clean;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-update bus between the binary-to-BCD stage (master) and the scan
// controller (slave).
//   load       strobe, one cycle: capture bcd_in/neg/window
//   bcd_in     five BCD digits, [3:0] units
//   neg        value is negative
//   window     0: show digits 3..0, 1: show digits 4..1
//   pending    shadow holds a value not yet committed
//   frame_done one-cycle pulse after each frame boundary
interface seg_scan_ctrl_if;
    import seg_scan_ctrl_pkg::*;

    logic                 load;
    logic [4*NUM_DIG-1:0] bcd_in;
    logic                 neg;
    logic                 window;
    logic                 pending;
    logic                 frame_done;

    modport master (
        output load, bcd_in, neg, window,
        input  pending, frame_done
    );

    modport slave (
        input  load, bcd_in, neg, window,
        output pending, frame_done
    );

endinterface

// File: rtl/seg_scan_ctrl_bcd_to_7seg.sv
// Single-digit decoder for a common-anode display.
//   code  in  4  0..9 digits, 4'hA minus, anything else blank
//   seg   out 7  {CA..CG}, active-low, purely combinational
module bcd_to_7seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            MINUS:   seg = 7'b1111110;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller.
// Holds a signed five-digit BCD magnitude, double-buffered: loads go to a
// shadow register and are committed to the active register only at a frame
// boundary, so a frame never mixes two values. The active value is scanned
// one position per REFRESH_DIV clocks with leading-zero blanking, a minus
// sign, and a selectable 4-digit window.
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport: load/bcd_in/neg/window in, pending/frame_done out
//   an    out  anode enables, active-low, an[0] rightmost
//   seg   out  {CA..CG}, active-low
//   dp    out  decimal point, active-low
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_ctrl_if.slave    bus,
    output an_mask_t          an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [1:0]       pos_reg;
    disp_val_t        shadow_reg;
    disp_val_t        active_reg;
    logic             pending_reg;
    logic             frame_done_reg;
    an_mask_t         an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;

    logic tc;
    logic boundary;

    assign tc       = (div_reg == DIV_LAST);
    assign boundary = tc && (pos_reg == 2'd3);

    // ------------------------------------------------------------------
    // Blanking and sign, all derived from the active register.
    // ------------------------------------------------------------------
    logic [3:0]         digit [NUM_DIG];
    logic [NUM_DIG-1:0] nz;
    logic [NUM_DIG-1:0] upper_nz;     // upper_nz[i]: any of digits i..4 non-zero
    logic [NUM_POS-1:0] lit;          // position not suppressed as a leading zero
    logic [NUM_POS-1:0] minus_at;
    logic [3:0]         code [NUM_POS];
    logic               mag_nz;
    logic               signed_val;
    logic               sign_dp;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
            assign digit[gi]    = active_reg.digits[4*gi +: 4];
            assign nz[gi]       = (digit[gi] != 4'd0);
            assign upper_nz[gi] = |nz[NUM_DIG-1:gi];
        end
    endgenerate

    assign mag_nz     = upper_nz[0];
    assign signed_val = active_reg.neg && mag_nz;

    // lit is a thermometer from position 0 upward, so the minus sign belongs
    // at the first unlit position directly above a lit one (L+1).
    generate
        for (gi = 0; gi < NUM_POS; gi++) begin : g_pos
            logic [3:0] digit_sel;
            assign digit_sel = active_reg.window ? digit[gi+1] : digit[gi];

            if (gi == 0) begin : g_first
                assign lit[gi]      = 1'b1;
                assign minus_at[gi] = 1'b0;
            end else begin : g_upper
                assign lit[gi]      = active_reg.window ? upper_nz[gi+1] : upper_nz[gi];
                assign minus_at[gi] = signed_val && lit[gi-1] && !lit[gi];
            end

            assign code[gi] = minus_at[gi] ? MINUS :
                              (lit[gi] ? digit_sel : BLANK);
        end
    endgenerate

    // All four positions occupied: no room for a minus, flag it with the dp.
    assign sign_dp = signed_val && lit[NUM_POS-1];

    logic [3:0] cur_code;
    logic [6:0] dec_seg;
    logic       cur_dp_lit;

    assign cur_code   = code[pos_reg];
    assign cur_dp_lit = ((pos_reg == 2'd0) && active_reg.window) ||
                        ((pos_reg == 2'd3) && sign_dp);

    bcd_to_7seg u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // ------------------------------------------------------------------
    // Scan counters, double buffer and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg        <= '0;
            pos_reg        <= '0;
            shadow_reg     <= DISP_ZERO;
            active_reg     <= DISP_ZERO;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            an_reg         <= AN_OFF;
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
        end else begin
            if (tc) begin
                div_reg <= '0;
                pos_reg <= pos_reg + 2'd1;
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end

            // A load on the boundary cycle still wins pending: the commit
            // below takes the old shadow and the new value waits a frame.
            if (bus.load) begin
                shadow_reg  <= '{digits: sanitize_bcd(bus.bcd_in),
                                 neg:    bus.neg,
                                 window: bus.window};
                pending_reg <= 1'b1;
            end else if (boundary) begin
                pending_reg <= 1'b0;
            end

            if (boundary && pending_reg) begin
                active_reg <= shadow_reg;
            end

            frame_done_reg <= boundary;

            an_reg  <= ~(an_mask_t'(1) << pos_reg);
            seg_reg <= dec_seg;
            dp_reg  <= ~cur_dp_lit;
        end
    end

    assign bus.pending    = pending_reg;
    assign bus.frame_done = frame_done_reg;
    assign an             = an_reg;
    assign seg            = seg_reg;
    assign dp             = dp_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SM = 7'b1111110;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct packed {
        logic [19:0]     bcd;
        logic            neg;
        logic            win;
        logic [3:0][6:0] seg;   // [3] is leftmost position
        logic [3:0]      dp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .an  (an),
        .seg (seg),
        .dp  (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [19:0] bcd, input logic neg, input logic win,
                                input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input logic [3:0] dpv);
        vec_t v;
        v.bcd = bcd;
        v.neg = neg;
        v.win = win;
        v.seg = {s3, s2, s1, s0};
        v.dp  = dpv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge where frame_done is high.
    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 80);
        if (!bus.frame_done) begin
            checks++;
            failures++;
            $display("FAIL %s frame_done timeout actual=0 expected=1", name);
        end
    endtask

    // Called at the frame_done negedge; samples the middle of each slot.
    task automatic check_frame(input string name, input logic [3:0][6:0] es, input logic [3:0] ed);
        logic [3:0] exp_an;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_an = 4'b1111 ^ (4'b0001 << k);
            check($sformatf("%s pos%0d an", name, k), {28'd0, an}, {28'd0, exp_an});
            check($sformatf("%s pos%0d seg", name, k), {25'd0, seg}, {25'd0, es[k]});
            check($sformatf("%s pos%0d dp", name, k), {31'd0, dp}, {31'd0, ed[k]});
            if (k < 3) repeat (DIV - 1) @(negedge clk);
        end
    endtask

    task automatic pulse_load(input logic [19:0] bcd, input logic neg, input logic win);
        @(negedge clk);
        bus.load   = 1'b1;
        bus.bcd_in = bcd;
        bus.neg    = neg;
        bus.window = win;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        int fd_count;
        int saw_seven;

        vecs[0] = mk(20'h00123, 1'b1, 1'b0, SM, S1, S2, S3, 4'b1111);
        vecs[1] = mk(20'h12345, 1'b1, 1'b0, S2, S3, S4, S5, 4'b0111);
        vecs[2] = mk(20'h12345, 1'b1, 1'b1, S1, S2, S3, S4, 4'b0110);
        vecs[3] = mk(20'h00C05, 1'b0, 1'b0, SB, SB, S0, S5, 4'b1111);
        vecs[4] = mk(20'h00000, 1'b1, 1'b0, SB, SB, SB, S0, 4'b1111);
        vecs[5] = mk(20'h00042, 1'b0, 1'b1, SB, SB, SB, S4, 4'b1110);
        vecs[6] = mk(20'h09870, 1'b1, 1'b0, S9, S8, S7, S0, 4'b0111);
        vecs[7] = mk(20'h00050, 1'b1, 1'b1, SB, SB, SM, S5, 4'b1110);

        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.neg    = 1'b0;
        bus.window = 1'b0;
        rst        = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset an", {28'd0, an}, 32'hF);
        check("reset seg", {25'd0, seg}, 32'h7F);
        check("reset dp", {31'd0, dp}, 32'h1);
        check("reset pending", {31'd0, bus.pending}, 32'h0);
        check("reset frame_done", {31'd0, bus.frame_done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("release an", {28'd0, an}, 32'hE);
        check("release seg", {25'd0, seg}, {25'd0, S0});
        $display("reset released: an=%b seg=%b", an, seg);
        wait_frame("post-reset");
        check_frame("post-reset", {SB, SB, SB, S0}, 4'b1111);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            pulse_load(vecs[i].bcd, vecs[i].neg, vecs[i].win);
            check($sformatf("vec%0d pending after load", i), {31'd0, bus.pending}, 32'h1);
            wait_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d pending after commit", i), {31'd0, bus.pending}, 32'h0);
            check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp);
            $display("vec %0d bcd=%05h neg=%0b win=%0b checked (checks=%0d)",
                     i, vecs[i].bcd, vecs[i].neg, vecs[i].win, checks);
        end

        // Two loads in one frame: only the latest may ever be shown.
        wait_frame("two-load sync");
        pulse_load(20'h00007, 1'b0, 1'b0);
        bus.load   = 1'b1;
        bus.bcd_in = 20'h00042;
        @(negedge clk);
        bus.load   = 1'b0;
        fd_count  = 0;
        saw_seven = 0;
        for (int c = 0; c < 8 * DIV; c++) begin
            @(negedge clk);
            if (bus.frame_done) fd_count++;
            if (seg == S7) saw_seven++;
        end
        check("two-load frame_done pulses", fd_count, 2);
        check("two-load seven shown", saw_seven, 0);
        wait_frame("two-load");
        check_frame("two-load", {SB, SB, S4, S2}, 4'b1111);
        $display("two-load sequence: frame_done pulses=%0d", fd_count);

        // Load on the boundary cycle: old shadow commits, new one a frame later.
        wait_frame("boundary sync");
        pulse_load(20'h00011, 1'b0, 1'b0);
        repeat (4 * DIV - 3) @(negedge clk);
        bus.load   = 1'b1;
        bus.bcd_in = 20'h00022;
        @(negedge clk);
        bus.load   = 1'b0;
        check("boundary frame_done", {31'd0, bus.frame_done}, 32'h1);
        check("boundary pending kept", {31'd0, bus.pending}, 32'h1);
        check_frame("boundary old", {SB, SB, S1, S1}, 4'b1111);
        wait_frame("boundary new");
        check("boundary pending cleared", {31'd0, bus.pending}, 32'h0);
        check_frame("boundary new", {SB, SB, S2, S2}, 4'b1111);
        $display("boundary-load sequence done");

        // Reset mid-frame with a load pending.
        wait_frame("reset sync");
        pulse_load(20'h00099, 1'b0, 1'b0);
        check("midreset pending before", {31'd0, bus.pending}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset an", {28'd0, an}, 32'hF);
        check("midreset seg", {25'd0, seg}, 32'h7F);
        check("midreset dp", {31'd0, dp}, 32'h1);
        check("midreset pending", {31'd0, bus.pending}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midreset release an", {28'd0, an}, 32'hE);
        check("midreset release seg", {25'd0, seg}, {25'd0, S0});
        wait_frame("midreset 1");
        check_frame("midreset frame1", {SB, SB, SB, S0}, 4'b1111);
        wait_frame("midreset 2");
        check_frame("midreset frame2", {SB, SB, SB, S0}, 4'b1111);
        $display("mid-frame reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Display controller for the Basys 3 four-digit, common-anode seven-segment display. It holds a signed five-digit BCD magnitude and time-multiplexes it onto the anodes:
- blanks leading zeros;
- places a minus sign;
- selects a 4-digit window.

New values are double-buffered and committed only at frame boundaries, so the display never tears. It sits between the multiplier's binary-to-BCD stage and the board pins, and drives the team's single-digit decoder, whose code 4'hA is minus and 4'hF is blank.

## Interface
- REFRESH_DIV, 100000: clocks per digit slot (100 MHz → 1 kHz per digit); minimum 2.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- load  in  1  single-cycle strobe; captures bcd_in, neg, window into the shadow register.
- bcd_in  in  20  five BCD digits; [3:0] is units, [19:16] is ten-thousands.
- neg  in  1  value is negative.
- window  in  1  0: show digits 3..0; 1: show digits 4..1.
- pending  out  1  shadow holds an uncommitted load.
- frame_done  out  1  one-cycle pulse at each frame boundary.
- an  out  4  anode enables, active-low; an[0] is the rightmost position.
- seg  out  7  {CA..CG}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- **Scan:**
  - div counts 0..REFRESH_DIV-1; at the terminal count ("tc") it wraps and pos advances 0→1→2→3→0.
  - Frame boundary = tc with pos==3.
- **Shadow capture:** on load, latch bcd_in, neg, window and set pending.
  - Any nibble >9 is stored as 4'hF (blank).
  - Load while pending overwrites the shadow; latest wins.
- **Commit:** at a frame boundary with pending=1, copy shadow → active and clear pending.
  - If load coincides with the boundary, the commit uses the old shadow. The new data is captured and pending stays 1.
- **Digit code for position p (0..3), w = window, d[i] = active digit i:**
  - Digit p shows d[p+w].
  - Position p is blank (4'hF) if p≠0 and d[p+w..4] are all zero.
  - Nibbles stored as 4'hF stay blank.
- **Sign:**
  - Let L = highest non-blank position.
  - If neg and the magnitude ≠ 0 and L<3: position L+1 shows 4'hA.
  - If neg and L==3: no minus; dp is lit on position 3.
  - A zero magnitude is never signed.
- **dp:** lit (0) on position 0 when w=1, and on position 3 under the no-room sign rule. Otherwise 1.
- **Outputs:** an, seg, dp are registered together; an = ~(1<<pos).
- **Reset:**
  - an=4'b1111, seg=7'b1111111, dp=1, pending=0, frame_done=0.
  - div=0, pos=0; active and shadow = all-zero digits, neg=0, window=0.

## Timing
- Output registers follow pos with 1-cycle latency; an, seg, dp always change in the same edge.
- Frame = 4×REFRESH_DIV cycles.
- Load-to-visible latency: from the next frame boundary plus 1 cycle. Worst case is 4×REFRESH_DIV+1 cycles.
- frame_done is asserted in the cycle after the boundary edge, i.e. the same cycle the committed data first drives position 0.
- Reset mid-frame: outputs blank asynchronously and any pending load is discarded. The first clock after release drives position 0 with "0" (seg=7'b0000001, an=4'b1110).

## Structure
- Shared package holds:
  - the decoder codes MINUS=4'hA and BLANK=4'hF;
  - NUM_POS=4 and NUM_DIG=5;
  - the segment constants SEG_OFF=7'h7F and the active-low anode mask type.
- One sub-module: instantiate the existing bcd_to_7seg on the current position's code. Register its seg output here.
- Blanking and sign logic is combinational from the active register plus pos; no further hierarchy.

## Test plan
Benches run with REFRESH_DIV=4.
- **Reset, then release:** outputs are an=1111, seg=1111111, dp=1 while rst=1. After release, frame shows only pos0 = 0000001, other positions blank (seg=1111111).
- **Load 0x00123, neg=1, window=0:** after the boundary, pos0=0000110 ("3"), pos1=0010010 ("2"), pos2=1001111 ("1"), pos3=1111110 ("-"). pending 1→0 at commit.
- **Load 0x12345, neg=1, window=0:** shows "2345"; pos3 dp=0; no minus.
  - Same value with window=1: shows "1234", pos0 dp=0, pos3 dp=0.
- **Two loads in one frame:** 0x00007 then 0x00042. Only "42" is ever displayed; frame_done pulses once per frame.
- **Load on the boundary cycle, or a nibble of 4'hC in bcd_in:**
  - Boundary load: the old shadow is committed, and the new value appears one frame later.
  - Invalid nibble: that position shows blank.
- **rst asserted mid-frame while pending=1:** outputs blank within the same cycle and pending=0. After release the display shows "0" and the discarded load never appears.
